// File: rtl/lsu_mem_if.sv
// lsu_mem_if
// Load/store unit between the single-cycle core datapath and a data memory
// port that uses a req/ready handshake. It steers RV32I byte/half/word
// lanes, generates byte enables, sign- or zero-extends load data, rejects
// misaligned or illegal accesses, and stalls the core until the access
// completes.
//
// Optional feature: define LSU_TIMEOUT_EN to abort a memory access that
// waits in REQ for TIMEOUT_CYCLES counted cycles without mem_ready. The
// aborted access responds with rsp_err=1. If the macro is not defined, REQ
// waits indefinitely.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   req_valid/req_we      core access request and direction (1=store)
//   req_funct3            RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   req_addr/req_wdata    byte address and store data (rs2)
//   stall                 hold PC and register write this cycle
//   rsp_valid             one-cycle completion pulse
//   rsp_rdata/rsp_err     extended load data and fault flag, valid with rsp_valid
//   mem_req/mem_we        memory request and write strobe
//   mem_addr/mem_be       word address and byte enables
//   mem_wdata             lane-replicated store data
//   mem_ready/mem_rdata   memory completion and read word
module lsu_mem_if #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  // Catch an out-of-range timeout setting when the design is elaborated.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("lsu_mem_if: TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  off_q, off_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

`ifdef LSU_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        timeout_hit;
  assign timeout_hit = (cnt_q == 16'(TIMEOUT_CYCLES));
`endif

  logic        req_legal;
  logic        size_ok;
  logic [3:0]  req_be;
  logic [31:0] req_wdata_lane;
  logic [31:0] rdata_shifted;
  logic [31:0] load_ext;

  // Request decode. funct3[1:0] encodes the access size for loads and
  // stores. funct3[2] marks the unsigned load variants and is never legal
  // on a store. Load funct3 6 is the only case where size_ok holds but the
  // encoding is still illegal.
  always_comb begin
    size_ok        = 1'b0;
    req_be         = 4'b1111;
    req_wdata_lane = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        size_ok        = 1'b1;
        req_be         = 4'b0001 << req_addr[1:0];
        req_wdata_lane = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        size_ok        = ~req_addr[0];
        req_be         = 4'b0011 << {req_addr[1], 1'b0};
        req_wdata_lane = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        size_ok        = (req_addr[1:0] == 2'b00);
        req_be         = 4'b1111;
        req_wdata_lane = req_wdata;
      end
      default: begin
        size_ok        = 1'b0;
        req_be         = 4'b1111;
        req_wdata_lane = req_wdata;
      end
    endcase
    if (req_we) begin
      req_legal = size_ok & ~req_funct3[2];
    end else begin
      req_legal = size_ok & ~(req_funct3[2] & req_funct3[1]);
    end
  end

  // Load extraction. Shift the addressed lane down to bit 0, then extend it.
  // For word loads the offset is always zero, so the shifted word is the
  // full read word.
  always_comb begin
    rdata_shifted = mem_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  load_ext = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      3'b001:  load_ext = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      3'b100:  load_ext = {24'b0, rdata_shifted[7:0]};
      3'b101:  load_ext = {16'b0, rdata_shifted[15:0]};
      default: load_ext = rdata_shifted;
    endcase
  end

  // State and datapath registers. A reset returns the FSM to IDLE at once,
  // which drops the Moore mem_* outputs in the same instant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= 32'b0;
      off_q    <= 2'b0;
      be_q     <= 4'b0;
      wdata_q  <= 32'b0;
      we_q     <= 1'b0;
      funct3_q <= 3'b0;
      rdata_q  <= 32'b0;
      err_q    <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      cnt_q    <= 16'b0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      off_q    <= off_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  // Next-state logic. RESP always returns to IDLE, so a request that is
  // still held high on the response cycle is not accepted twice.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    off_d    = off_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          rdata_d = 32'b0;
          if (req_legal) begin
            addr_d   = {req_addr[31:2], 2'b00};
            off_d    = req_addr[1:0];
            be_d     = req_be;
            wdata_d  = req_wdata_lane;
            we_d     = req_we;
            funct3_d = req_funct3;
            err_d    = 1'b0;
            state_d  = ST_REQ;
`ifdef LSU_TIMEOUT_EN
            cnt_d    = 16'b0;
`endif
          end else begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_REQ: begin
        // Once issued, the access always completes, even if req_valid drops.
        if (mem_ready) begin
          rdata_d = we_q ? 32'b0 : load_ext;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end
`ifdef LSU_TIMEOUT_EN
        else if (timeout_hit) begin
          rdata_d = 32'b0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs. Memory signals come from registers and are zero outside REQ.
  // Response signals are zero outside RESP. Stall is gated by reset so the
  // core is released immediately when reset is asserted.
  always_comb begin
    mem_req   = (state_q == ST_REQ);
    mem_we    = mem_req & we_q;
    mem_addr  = mem_req ? addr_q : 32'b0;
    mem_be    = mem_req ? be_q : 4'b0;
    mem_wdata = mem_req ? wdata_q : 32'b0;
    rsp_valid = (state_q == ST_RESP);
    rsp_rdata = rsp_valid ? rdata_q : 32'b0;
    rsp_err   = rsp_valid & err_q;
    stall     = req_valid & ~reset & (state_q != ST_RESP);
  end

endmodule

// File: tb/tb_lsu_mem_if.sv
// tb_lsu_mem_if
// Directed bench for lsu_mem_if. The stimulus task pushes the expected
// response into a scoreboard queue. An independent monitor pops an entry
// and compares it on every rsp_valid. Handshake timing and the mem_* fields
// are checked inside the stimulus task. Build with +define+LSU_TIMEOUT_EN
// to also run the timeout scenario, which uses TIMEOUT_CYCLES=4.
module tb_lsu_mem_if;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  // Each entry is {err, rdata}.
  logic [32:0] scoreboard[$];

  lsu_mem_if #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
  );

  // Free-running clock with a 10-unit period. Rising edges fall at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute time limit so the bench always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point that updates the counters.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Monitor: every response must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!reset && rsp_valid) begin
      if (scoreboard.size() == 0) begin
        checkOutput("sb_unexpected_rsp", {63'b0, rsp_valid}, 64'd0);
      end else begin
        logic [32:0] exp;
        exp = scoreboard.pop_front();
        checkOutput("rsp_rdata", {32'b0, rsp_rdata}, {32'b0, exp[31:0]});
        checkOutput("rsp_err", {63'b0, rsp_err}, {63'b0, exp[32]});
      end
    end
  end

  // Issues one access and acts as the memory. The memory asserts mem_ready
  // after ready_delay REQ cycles. The task checks the mem_* fields on the
  // first REQ cycle, the number of REQ cycles, the response cycle (relative
  // to the request cycle 0) and the number of stall cycles.
  task automatic applyStimulus(
    input string       name,
    input logic        we,
    input logic [2:0]  f3,
    input logic [31:0] addr,
    input logic [31:0] wdata,
    input logic [31:0] mem_word,
    input int          ready_delay,
    input logic        drop_early,
    input logic [31:0] exp_rdata,
    input logic        exp_err,
    input logic [31:0] exp_mem_addr,
    input logic [3:0]  exp_be,
    input logic [31:0] exp_wdata,
    input int          exp_req_cycles,
    input int          exp_rsp_cycle
  );
    int req_cyc;
    int stall_cyc;
    int rsp_cyc;
    scoreboard.push_back({exp_err, exp_rdata});
    @(posedge clk); #1;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    mem_ready  = 1'b0;
    req_cyc    = 0;
    stall_cyc  = 0;
    rsp_cyc    = -1;
    for (int t = 0; t < 64 && rsp_cyc < 0; t++) begin
      if (mem_req) begin
        mem_ready = (req_cyc >= ready_delay);
        mem_rdata = mem_word;
      end else begin
        mem_ready = 1'b0;
      end
      @(negedge clk);
      if (mem_req) begin
        if (req_cyc == 0) begin
          checkOutput({name, "_mem_addr"}, {32'b0, mem_addr}, {32'b0, exp_mem_addr});
          checkOutput({name, "_mem_be"}, {60'b0, mem_be}, {60'b0, exp_be});
          checkOutput({name, "_mem_we"}, {63'b0, mem_we}, {63'b0, we});
          checkOutput({name, "_mem_wdata"}, {32'b0, mem_wdata}, {32'b0, exp_wdata});
        end
        req_cyc++;
      end
      if (stall) stall_cyc++;
      if (rsp_valid) rsp_cyc = t;
      @(posedge clk); #1;
      if (drop_early && t == 1) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    mem_ready = 1'b0;
    checkOutput({name, "_rsp_cycle"}, 64'(rsp_cyc), 64'(exp_rsp_cycle));
    checkOutput({name, "_req_cycles"}, 64'(req_cyc), 64'(exp_req_cycles));
    if (!drop_early) begin
      checkOutput({name, "_stall_cycles"}, 64'(stall_cyc), 64'(exp_rsp_cycle));
    end
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b0;
    req_addr   = 32'b0;
    req_wdata  = 32'b0;
    mem_ready  = 1'b0;
    mem_rdata  = 32'b0;

    // Reset values.
    #3;
    checkOutput("reset_stall", {63'b0, stall}, 64'd0);
    checkOutput("reset_rsp_valid", {63'b0, rsp_valid}, 64'd0);
    checkOutput("reset_rsp_rdata", {32'b0, rsp_rdata}, 64'd0);
    checkOutput("reset_rsp_err", {63'b0, rsp_err}, 64'd0);
    checkOutput("reset_mem_req", {63'b0, mem_req}, 64'd0);
    checkOutput("reset_mem_be", {60'b0, mem_be}, 64'd0);
    checkOutput("reset_mem_addr", {32'b0, mem_addr}, 64'd0);
    checkOutput("reset_mem_wdata", {32'b0, mem_wdata}, 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    $display("[TB] reset released");

    // mem_ready is ignored while the unit is idle.
    mem_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("idle_ready_mem_req", {63'b0, mem_req}, 64'd0);
    end
    @(posedge clk); #1;
    mem_ready = 1'b0;

    //             name        we   f3    addr          wdata         mem_word      dly drop rdata         err   mem_addr      be       wdata        req rsp
    applyStimulus("lw",        0, 3'd2, 32'h00000010, 32'h00000000, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 1'b0, 32'h00000010, 4'b1111, 32'h00000000, 1, 2);
    applyStimulus("lb",        0, 3'd0, 32'h00000013, 32'h00000000, 32'h80FF1234, 0, 0, 32'hFFFFFF80, 1'b0, 32'h00000010, 4'b1000, 32'h00000000, 1, 2);
    applyStimulus("lbu",       0, 3'd4, 32'h00000013, 32'h00000000, 32'h80FF1234, 0, 0, 32'h00000080, 1'b0, 32'h00000010, 4'b1000, 32'h00000000, 1, 2);
    applyStimulus("sh",        1, 3'd1, 32'h00000022, 32'h0000ABCD, 32'h00000000, 3, 0, 32'h00000000, 1'b0, 32'h00000020, 4'b1100, 32'hABCDABCD, 4, 5);
    applyStimulus("lw_misal",  0, 3'd2, 32'h00000006, 32'h00000000, 32'h00000000, 0, 0, 32'h00000000, 1'b1, 32'h00000000, 4'b0000, 32'h00000000, 0, 1);
    applyStimulus("lh",        0, 3'd1, 32'h00000012, 32'h00000000, 32'h80FF1234, 1, 0, 32'hFFFF80FF, 1'b0, 32'h00000010, 4'b1100, 32'h00000000, 2, 3);
    applyStimulus("lhu",       0, 3'd5, 32'h00000010, 32'h00000000, 32'h80FF8234, 0, 0, 32'h00008234, 1'b0, 32'h00000010, 4'b0011, 32'h00000000, 1, 2);
    applyStimulus("sb",        1, 3'd0, 32'h00000001, 32'h123456A5, 32'h00000000, 0, 0, 32'h00000000, 1'b0, 32'h00000000, 4'b0010, 32'hA5A5A5A5, 1, 2);
    applyStimulus("sw",        1, 3'd2, 32'h0000002C, 32'hCAFEF00D, 32'h00000000, 1, 0, 32'h00000000, 1'b0, 32'h0000002C, 4'b1111, 32'hCAFEF00D, 2, 3);
    applyStimulus("lh_misal",  0, 3'd1, 32'h00000011, 32'h00000000, 32'h00000000, 0, 0, 32'h00000000, 1'b1, 32'h00000000, 4'b0000, 32'h00000000, 0, 1);
    applyStimulus("ld_f3_3",   0, 3'd3, 32'h00000000, 32'h00000000, 32'h00000000, 0, 0, 32'h00000000, 1'b1, 32'h00000000, 4'b0000, 32'h00000000, 0, 1);
    applyStimulus("ld_f3_6",   0, 3'd6, 32'h00000000, 32'h00000000, 32'h00000000, 0, 0, 32'h00000000, 1'b1, 32'h00000000, 4'b0000, 32'h00000000, 0, 1);
    applyStimulus("st_f3_4",   1, 3'd4, 32'h00000000, 32'h00000000, 32'h00000000, 0, 0, 32'h00000000, 1'b1, 32'h00000000, 4'b0000, 32'h00000000, 0, 1);
    applyStimulus("lb_drop",   0, 3'd0, 32'h00000012, 32'h00000000, 32'h80FF1234, 2, 1, 32'hFFFFFFFF, 1'b0, 32'h00000010, 4'b0100, 32'h00000000, 3, 4);

    // Reset in the second REQ cycle drops mem_req and stall immediately and
    // produces no response.
    @(posedge clk); #1;
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'd2;
    req_addr   = 32'h00000040;
    mem_ready  = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("rst_mid_pre_mem_req", {63'b0, mem_req}, 64'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_mid_mem_req", {63'b0, mem_req}, 64'd0);
    checkOutput("rst_mid_stall", {63'b0, stall}, 64'd0);
    checkOutput("rst_mid_rsp_valid", {63'b0, rsp_valid}, 64'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("rst_after_mem_req", {63'b0, mem_req}, 64'd0);
    end
    applyStimulus("lw_post_rst", 0, 3'd2, 32'h00000040, 32'h00000000, 32'h0BADF00D, 0, 0, 32'h0BADF00D, 1'b0, 32'h00000040, 4'b1111, 32'h00000000, 1, 2);

`ifdef LSU_TIMEOUT_EN
    // With TIMEOUT_CYCLES=4 and no mem_ready, mem_req is high for 5 cycles
    // and the error response follows in the next cycle.
    applyStimulus("lw_timeout", 0, 3'd2, 32'h00000030, 32'h00000000, 32'h11111111, 1000, 0, 32'h00000000, 1'b1, 32'h00000030, 4'b1111, 32'h00000000, 5, 6);
`endif

    repeat (3) @(posedge clk);
    checkOutput("sb_empty", 64'(scoreboard.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_if.md
Name: lsu_mem_if

Overview:
- Load/store unit between the single-cycle core datapath (ALU address, rs2 data, MemRead/MemWrite, funct3) and a data memory port with a req/ready handshake.
- Performs RV32I byte/half/word lane steering, byte-enable generation and load sign/zero extension.
- Detects misaligned and illegal accesses.
- Stalls the core (PC hold, register write hold) until the access completes.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles in REQ waiting for mem_ready before the access is aborted. Only used when LSU_TIMEOUT_EN is defined. Range 1..65535.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- req_valid  in  1  core access request (MemRead|MemWrite); held stable while stall=1
- req_we  in  1  1=store, 0=load
- req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- req_addr  in  32  byte address from ALU
- req_wdata  in  32  store data (rs2)
- stall  out  1  hold core state this cycle
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data, valid with rsp_valid
- rsp_err  out  1  access fault, valid with rsp_valid
- mem_req  out  1  memory request
- mem_we  out  1  memory write
- mem_addr  out  32  word address, {req_addr[31:2],2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_ready  in  1  memory accepts/completes the access this cycle
- mem_rdata  in  32  read word, valid when mem_ready=1 on a load

Behaviour:
- Reset values: stall=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0. FSM=IDLE.
- FSM states and transitions:
  - IDLE: req_valid=1 and access legal → latch address, be, wdata and funct3 into registers; go to REQ. req_valid=1 and access illegal → go to RESP with err flag set, no memory access.
  - REQ: mem_req=1 and all mem_* driven from registers (Moore). mem_ready=1 → capture mem_rdata (loads); go to RESP.
  - RESP: rsp_valid=1 for exactly one cycle; always return to IDLE, never re-accepting in this cycle.
- stall = req_valid & (state != RESP), combinational. The core advances exactly on the rsp_valid cycle.
- Latency: request in cycle 0, mem_req from cycle 1. If mem_ready is seen in cycle N, rsp_valid is in cycle N+1. Minimum request-to-response is 2 cycles. An illegal access gives rsp_valid in cycle 1.
- Legality rules:
  - Half access is illegal if addr[0]=1.
  - Word access is illegal if addr[1:0]!=0.
  - Load funct3 3, 6 and 7 are illegal.
  - Store funct3 >2 is illegal.
  - Illegal access response: rsp_err=1, rsp_rdata=0.
- Byte enables:
  - SB/LB/LBU: 4'b0001<<addr[1:0].
  - SH/LH/LHU: 4'b0011<<{addr[1],1'b0}.
  - SW/LW: 4'b1111.
- Store data: SB replicates wdata[7:0] ×4. SH replicates wdata[15:0] ×2. SW passes wdata through.
- Load extract: select the byte/half from the lane at addr[1:0]. LB/LH sign-extend to 32. LBU/LHU zero-extend.
- For a store response, rsp_rdata=0.
- mem_ready while in IDLE or RESP is ignored.
- mem_rdata is sampled only in REQ with mem_ready=1.
- req_valid dropping while in REQ: the access still completes, since the memory must not see a withdrawn request. rsp_valid is still pulsed.
- Reset mid-access: FSM returns to IDLE immediately (asynchronously) and mem_req drops in the same instant. No response is produced.

Optional Feature:
- LSU_TIMEOUT_EN.
- When defined:
  - A 16-bit counter clears on entry to REQ and increments each REQ cycle without mem_ready.
  - When the count reaches TIMEOUT_CYCLES and mem_ready=0, mem_req drops and the FSM goes to RESP with rsp_err=1, rsp_rdata=0.
  - If mem_ready=1 in the same cycle the count is reached, the completion wins and rsp_err=0.
- When undefined: no counter is present, and REQ waits indefinitely.

Test Plan:
- LW: addr 0x00000010, mem_rdata 0xDEADBEEF, mem_ready in the first REQ cycle → mem_addr 0x10, mem_be 1111. rsp_valid 2 cycles after the request, rsp_rdata 0xDEADBEEF, stall high for exactly 2 cycles.
- LB vs LBU: addr 0x13, mem_rdata 0x80FF1234 → mem_be 1000. LB gives 0xFFFFFF80, LBU gives 0x00000080.
- SH: addr 0x22, wdata 0x0000ABCD, mem_ready delayed 3 cycles → mem_we=1, mem_be 1100, mem_wdata 0xABCDABCD. mem_req held 4 cycles, rsp_valid 1 cycle later with rsp_rdata 0.
- Misaligned LW at 0x06 → mem_req never asserts. rsp_valid with rsp_err=1 in cycle 1.
- Reset asserted in the second REQ cycle → mem_req and stall go to 0 immediately. No rsp_valid. A subsequent LW completes normally.
- LSU_TIMEOUT_EN with TIMEOUT_CYCLES=4 and mem_ready held at 0 → mem_req high for 5 cycles, then rsp_valid with rsp_err=1.
